regfile_led_reader: RTL and testbench



---
 rtl/regfile_reader_pkg.sv | 25 ++
 rtl/dwell_timer.sv | 29 ++
 rtl/regfile_led_reader.sv | 160 ++++++++++++++++
 tb/tb_regfile_led_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_reader_pkg.sv
// Shared types and constants for the register-file LED reader.
package regfile_reader_pkg;

  localparam int ADDR_W         = 5;
  localparam int DATA_W         = 32;
  localparam int LED_W          = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SHOW,
    DONE
  } state_t;

  // Select byte idx of a word (idx 0 = least significant byte).
  function automatic logic [LED_W-1:0] word_byte(input logic [DATA_W-1:0] word,
                                                 input logic [1:0]        idx);
    logic [DATA_W-1:0] shifted;
    shifted = word >> {idx, 3'b000};
    return shifted[LED_W-1:0];
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell timer: counts enabled cycles and flags the last cycle of each
// DWELL_CYCLES-long period, then restarts from zero on its own.
module dwell_timer #(
  parameter int DWELL_CYCLES = 4,
  parameter int DWELL_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL_CYCLES - 1);

  logic [DWELL_W-1:0] count;

  assign expire = enable && (count == LAST);

  // Count enabled cycles, wrapping to zero on the expiring cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expire ? '0 : count + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/regfile_led_reader.sv
// Register-file LED reader: scans addresses Addr_Lo..Addr_Hi (modulo 32) and
// shows each word on the LED bank one byte at a time, DWELL_CYCLES per byte.
// Optional build macro REGFILE_READER_SKIP_ZERO_EN: all-zero words are not
// displayed; the scan moves straight on and LED/Byte_Idx keep their values.
//
// state   | meaning
// IDLE    | waiting for Start
// FETCH   | Rd_Addr just updated, read data settling
// CAPTURE | latch Rd_Data, show byte 0
// SHOW    | hold current byte for the dwell period, then next byte/word
// DONE    | one-cycle Done pulse
module regfile_led_reader
  import regfile_reader_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int DWELL_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr_Lo,
  input  logic [ADDR_W-1:0] Addr_Hi,
  output logic [ADDR_W-1:0] Rd_Addr,
  input  logic [DATA_W-1:0] Rd_Data,
  output logic [LED_W-1:0]  LED,
  output logic [1:0]        Byte_Idx,
  output logic              Busy,
  output logic              Done
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] hi_addr;
  logic [DATA_W-1:0] word;

  logic load_start;
  logic capture;
  logic next_byte;
  logic adv_addr;
  logic dwell_clear;
  logic dwell_en;
  logic dwell_exp;
  logic last_addr;
  logic skip_word;

  assign last_addr = (Rd_Addr == hi_addr);

`ifdef REGFILE_READER_SKIP_ZERO_EN
  assign skip_word = (Rd_Data == '0);
`else
  assign skip_word = 1'b0;
`endif

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .DWELL_W     (DWELL_W)
  ) u_dwell (
    .clk   (Clk),
    .reset (Reset),
    .clear (dwell_clear),
    .enable(dwell_en),
    .expire(dwell_exp)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_nxt   = state;
    load_start  = 1'b0;
    capture     = 1'b0;
    next_byte   = 1'b0;
    adv_addr    = 1'b0;
    dwell_clear = 1'b0;
    dwell_en    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load_start = 1'b1;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (skip_word) begin
          if (last_addr) begin
            state_nxt = DONE;
          end else begin
            adv_addr  = 1'b1;
            state_nxt = FETCH;
          end
        end else begin
          capture     = 1'b1;
          dwell_clear = 1'b1;
          state_nxt   = SHOW;
        end
      end
      SHOW: begin
        dwell_en = 1'b1;
        if (dwell_exp) begin
          if (Byte_Idx != 2'(BYTES_PER_WORD - 1)) begin
            next_byte = 1'b1;
          end else if (last_addr) begin
            state_nxt = DONE;
          end else begin
            adv_addr  = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address, captured word and LED/byte-index registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Rd_Addr  <= '0;
      hi_addr  <= '0;
      word     <= '0;
      LED      <= '0;
      Byte_Idx <= '0;
    end else begin
      if (load_start) begin
        Rd_Addr <= Addr_Lo;
        hi_addr <= Addr_Hi;
      end
      if (adv_addr) begin
        Rd_Addr <= Rd_Addr + ADDR_W'(1);
      end
      if (capture) begin
        word     <= Rd_Data;
        LED      <= Rd_Data[LED_W-1:0];
        Byte_Idx <= 2'd0;
      end
      if (next_byte) begin
        Byte_Idx <= Byte_Idx + 2'd1;
        LED      <= word_byte(word, Byte_Idx + 2'd1);
      end
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_regfile_led_reader.sv
// Testbench for regfile_led_reader: a register-file array drives Rd_Data, and
// a reference model builds the expected per-cycle trace of every scan.
module tb_regfile_led_reader;

  localparam int DWELL = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [4:0]  Addr_Lo;
  logic [4:0]  Addr_Hi;
  logic [4:0]  Rd_Addr;
  logic [31:0] Rd_Data;
  logic [7:0]  LED;
  logic [1:0]  Byte_Idx;
  logic        Busy;
  logic        Done;

  logic [31:0] mem [32];

  int checks   = 0;
  int failures = 0;

  // Model of the displayed value carried across scans.
  logic [7:0] m_led;
  logic [1:0] m_idx;

  typedef struct packed {
    logic [7:0] led;
    logic [1:0] idx;
    logic [4:0] addr;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t exp_q[$];

  regfile_led_reader #(
    .DWELL_CYCLES(DWELL),
    .DWELL_W     (16)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Addr_Lo (Addr_Lo),
    .Addr_Hi (Addr_Hi),
    .Rd_Addr (Rd_Addr),
    .Rd_Data (Rd_Data),
    .LED     (LED),
    .Byte_Idx(Byte_Idx),
    .Busy    (Busy),
    .Done    (Done)
  );

  assign Rd_Data = mem[Rd_Addr];

  always #5 Clk = ~Clk;

  function automatic obs_t observe();
    obs_t o;
    o.led  = LED;
    o.idx  = Byte_Idx;
    o.addr = Rd_Addr;
    o.busy = Busy;
    o.done = Done;
    return o;
  endfunction

  function automatic bit skip_zero_build();
`ifdef REGFILE_READER_SKIP_ZERO_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected trace, one entry per cycle sampled after edge 0 (the edge that
  // accepts Start): per register two cycles of fetch/capture showing the
  // previous LED value, then four bytes each held DWELL cycles; then one Done
  // cycle and two idle cycles.
  function automatic void build_expected(input logic [4:0] lo, input logic [4:0] hi);
    int    n;
    obs_t  o;
    logic [31:0] w;
    logic [4:0]  a;
    n = ((int'(hi) - int'(lo) + 32) % 32) + 1;
    for (int j = 0; j < n; j++) begin
      a = 5'((int'(lo) + j) % 32);
      w = mem[a];
      for (int c = 0; c < 2; c++) begin
        o = '{led: m_led, idx: m_idx, addr: a, busy: 1'b1, done: 1'b0};
        exp_q.push_back(o);
      end
      if (!(skip_zero_build() && w == 32'h0)) begin
        for (int b = 0; b < 4; b++) begin
          m_led = w[8*b +: 8];
          m_idx = 2'(b);
          for (int d = 0; d < DWELL; d++) begin
            o = '{led: m_led, idx: m_idx, addr: a, busy: 1'b1, done: 1'b0};
            exp_q.push_back(o);
          end
        end
      end
    end
    o = '{led: m_led, idx: m_idx, addr: hi, busy: 1'b1, done: 1'b1};
    exp_q.push_back(o);
    for (int c = 0; c < 2; c++) begin
      o = '{led: m_led, idx: m_idx, addr: hi, busy: 1'b0, done: 1'b0};
      exp_q.push_back(o);
    end
  endfunction

  // Runs one scan from a negedge; with disturb set, Start is re-pulsed and
  // mem[lo] overwritten while the first word is on display.
  task automatic run_scan(input string tag, input logic [4:0] lo,
                          input logic [4:0] hi, input bit disturb);
    obs_t got;
    build_expected(lo, hi);
    Start   = 1'b1;
    Addr_Lo = lo;
    Addr_Hi = hi;
    @(negedge Clk);
    Start   = 1'b0;
    Addr_Lo = 5'($urandom);
    Addr_Hi = 5'($urandom);
    for (int k = 0; k < exp_q.size(); k++) begin
      got = observe();
      checks++;
      if (got !== exp_q[k]) begin
        failures++;
        $display("FAIL %s cyc %0d: got led=%h idx=%0d addr=%0d busy=%b done=%b, expected led=%h idx=%0d addr=%0d busy=%b done=%b",
                 tag, k, got.led, got.idx, got.addr, got.busy, got.done,
                 exp_q[k].led, exp_q[k].idx, exp_q[k].addr, exp_q[k].busy, exp_q[k].done);
      end
      if (disturb && k == 4) begin
        Start    = 1'b1;
        Addr_Lo  = 5'($urandom);
        Addr_Hi  = 5'($urandom);
        mem[lo]  = 32'hFFFF_FFFF;
      end
      if (disturb && k == 5) Start = 1'b0;
      @(negedge Clk);
    end
    exp_q.delete();
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    obs_t got;
    for (int k = 0; k < cycles; k++) begin
      got = observe();
      checks++;
      if (got !== obs_t'(0)) begin
        failures++;
        $display("FAIL %s cyc %0d: got led=%h idx=%0d addr=%0d busy=%b done=%b, expected all zero",
                 tag, k, got.led, got.idx, got.addr, got.busy, got.done);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    Start   = 1'b1;
    Addr_Lo = 5'd3;
    Addr_Hi = 5'd9;
    @(negedge Clk);
    check_quiet("reset_hold", 10);
    Reset = 1'b0;
    Start = 1'b0;
    check_quiet("reset_idle", 4);
    m_led = 8'h00;
    m_idx = 2'd0;
  endtask

  task automatic test_single();
    mem[3] = 32'hA1B2_C3D4;
    run_scan("single", 5'd3, 5'd3, 1'b0);
  endtask

  task automatic test_range();
    mem[5] = 32'h0102_0304;
    mem[6] = 32'h1112_1314;
    mem[7] = 32'h2122_2324;
    run_scan("range", 5'd5, 5'd7, 1'b0);
  endtask

  task automatic test_wrap();
    mem[30] = 32'hDEAD_BEEF;
    mem[31] = 32'h1357_9BDF;
    mem[0]  = 32'h2468_ACE0;
    mem[1]  = 32'hC0FF_EE11;
    run_scan("wrap", 5'd30, 5'd1, 1'b0);
  endtask

  task automatic test_busy_ignore();
    mem[5] = 32'h5A6B_7C8D;
    mem[6] = 32'h0F1E_2D3C;
    run_scan("busy_ignore", 5'd5, 5'd6, 1'b1);
  endtask

  task automatic test_reset_mid();
    obs_t got;
    mem[10] = 32'h8899_AABB;
    mem[11] = 32'h1122_3344;
    Start   = 1'b1;
    Addr_Lo = 5'd10;
    Addr_Hi = 5'd11;
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    checks++;
    if (LED !== 8'hBB || Busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: got led=%h busy=%b, expected led=bb busy=1", LED, Busy);
    end
    Reset = 1'b1;
    @(negedge Clk);
    got = observe();
    checks++;
    if (got !== obs_t'(0)) begin
      failures++;
      $display("FAIL reset_mid_abort: got led=%h idx=%0d addr=%0d busy=%b done=%b, expected all zero",
               got.led, got.idx, got.addr, got.busy, got.done);
    end
    Reset = 1'b0;
    check_quiet("reset_mid_after", 8);
    m_led = 8'h00;
    m_idx = 2'd0;
  endtask

  task automatic test_skip_zero();
    mem[8] = 32'h0000_0000;
    mem[9] = 32'h0000_00AA;
    run_scan("skip_zero", 5'd8, 5'd9, 1'b0);
  endtask

  task automatic test_random();
    logic [4:0] lo;
    logic [4:0] hi;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      end
      lo = 5'($urandom_range(0, 31));
      hi = lo + 5'($urandom_range(0, 5));
      run_scan($sformatf("random%0d", t), lo, hi, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    Reset   = 1'b1;
    Start   = 1'b0;
    Addr_Lo = 5'd0;
    Addr_Hi = 5'd0;
    m_led   = 8'h00;
    m_idx   = 2'd0;
    test_reset();
    test_single();
    test_range();
    test_wrap();
    test_busy_ignore();
    test_reset_mid();
    test_skip_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
